axi_stream_packetizer: RTL and testbench



---
 rtl/axi_stream_packetizer_if.sv | 24 ++
 rtl/axi_stream_packetizer.sv | 137 +++++++++++++
 tb/tb_axi_stream_packetizer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_packetizer_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | if_axi_stream : AXI-stream word bus with sop/eop/mod/ctl framing |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS);

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;
  logic [DAT_BYTS*8-1:0] dat;

  modport source (output val, sop, eop, err, mod, ctl, dat, input rdy);
  modport sink   (input val, sop, eop, err, mod, ctl, dat, output rdy);
endinterface
`default_nettype wire

// File: rtl/axi_stream_packetizer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | axi_stream_packetizer : frames raw words into AXI-stream packets |
// | using a byte-length descriptor. Rev 1.0                          |
// +-----------------------------------------------------------------+
module axi_stream_packetizer #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8,
  parameter int LEN_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_len_val,
  input  logic [LEN_BITS-1:0] i_len,
  input  logic [CTL_BITS-1:0] i_len_ctl,
  output logic                o_len_rdy,
  if_axi_stream.sink          i_axi,
  if_axi_stream.source        o_axi,
  output logic                o_zero_len
);

  localparam int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS);
  localparam logic [LEN_BITS-1:0] c_word_byts = LEN_BITS'(DAT_BYTS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t                r_state;
  logic [LEN_BITS-1:0]   r_rem;
  logic [CTL_BITS-1:0]   r_ctl;
  logic                  r_first;

  logic                  r_val;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_err;
  logic [MOD_BITS-1:0]   r_mod;
  logic [CTL_BITS-1:0]   r_out_ctl;
  logic [DAT_BYTS*8-1:0] r_dat;
  logic                  r_zero_len;

  logic                  w_len_rdy;
  logic                  w_in_rdy;
  logic                  w_in_hs;
  logic                  w_last;
  logic [MOD_BITS-1:0]   w_last_mod;
  logic                  w_unused;

  assign w_len_rdy = (r_state == S_IDLE) && !i_rst;
  assign w_in_rdy  = (r_state == S_DATA) && (!r_val || o_axi.rdy);
  assign w_in_hs   = i_axi.val && w_in_rdy;
  assign w_last    = (r_rem <= c_word_byts);

  // Framing fields of the raw stream carry no meaning here.
  assign w_unused = ^{i_axi.sop, i_axi.eop, i_axi.mod, i_axi.ctl};

  generate
    if (DAT_BYTS == 1) begin : g_mod_byte
      assign w_last_mod = 1'b0;
    end else begin : g_mod_word
      assign w_last_mod = r_rem[MOD_BITS-1:0];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_ctl      <= '0;
      r_first    <= 1'b0;
      r_val      <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_err      <= 1'b0;
      r_mod      <= '0;
      r_out_ctl  <= '0;
      r_dat      <= '0;
      r_zero_len <= 1'b0;
    end else begin
      r_zero_len <= 1'b0;
      if (o_axi.rdy) begin
        r_val <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_len_val) begin
            if (i_len != '0) begin
              r_rem   <= i_len;
              r_ctl   <= i_len_ctl;
              r_first <= 1'b1;
              r_state <= S_DATA;
            end else begin
              r_zero_len <= 1'b1;
            end
          end
        end
        S_DATA: begin
          // A load only happens when the output slot is free or draining,
          // so held fields never change under a stall.
          if (w_in_hs) begin
            r_val     <= 1'b1;
            r_dat     <= i_axi.dat;
            r_err     <= i_axi.err;
            r_sop     <= r_first;
            r_out_ctl <= r_ctl;
            r_first   <= 1'b0;
            if (w_last) begin
              r_eop   <= 1'b1;
              r_mod   <= w_last_mod;
              r_state <= S_IDLE;
            end else begin
              r_eop   <= 1'b0;
              r_mod   <= '0;
              r_rem   <= r_rem - c_word_byts;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_len_rdy  = w_len_rdy;
  assign o_zero_len = r_zero_len;
  assign i_axi.rdy  = w_in_rdy;
  assign o_axi.val  = r_val;
  assign o_axi.sop  = r_sop;
  assign o_axi.eop  = r_eop;
  assign o_axi.err  = r_err;
  assign o_axi.mod  = r_mod;
  assign o_axi.ctl  = r_out_ctl;
  assign o_axi.dat  = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_packetizer.sv
`default_nettype none
// Directed bench for axi_stream_packetizer: table of packets plus
// hand sequences for zero-length, back-to-back and mid-packet reset.
module tb_axi_stream_packetizer;
  localparam int DB = 8;
  localparam int CB = 8;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          len_val = 1'b0;
  logic [LB-1:0] len = '0;
  logic [CB-1:0] len_ctl = '0;
  logic          len_rdy;
  logic          zero_len;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            bp_rand = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB)) in_if ();
  if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(CB)) out_if ();

  axi_stream_packetizer #(.DAT_BYTS(DB), .CTL_BITS(CB), .LEN_BITS(LB)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_len_val  (len_val),
    .i_len      (len),
    .i_len_ctl  (len_ctl),
    .o_len_rdy  (len_rdy),
    .i_axi      (in_if),
    .o_axi      (out_if),
    .o_zero_len (zero_len)
  );

  typedef struct {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  mod;
    logic [7:0]  ctl;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  ctl;
    int          nw;
    logic [2:0]  lmod;
    bit          bp;
    bit          gaps;
  } vec_t;

  beat_t q_out[$];
  int    hs_cyc[$];
  beat_t prev;
  bit    prev_stall = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Output monitor: records every handshaken beat and checks hold under stall.
  always @(negedge clk) begin
    beat_t b;
    b.dat = out_if.dat; b.sop = out_if.sop; b.eop = out_if.eop;
    b.err = out_if.err; b.mod = out_if.mod; b.ctl = out_if.ctl; b.cyc = cyc;
    if (prev_stall)
      chk("stall_hold", {b.dat, b.sop, b.eop, b.err, b.mod, b.ctl, out_if.val},
          {prev.dat, prev.sop, prev.eop, prev.err, prev.mod, prev.ctl, 1'b1});
    prev_stall = out_if.val && !out_if.rdy && !rst;
    prev = b;
    if (out_if.val && out_if.rdy) q_out.push_back(b);
  end

  always @(posedge clk) begin
    #1;
    out_if.rdy = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic desc(input logic [15:0] l, input logic [7:0] c, output int acc);
    len_val = 1'b1; len = l; len_ctl = c; acc = -1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (len_rdy) begin
        acc = cyc + 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    len_val = 1'b0;
    if (acc < 0) bound_fail("desc_accept");
  endtask

  task automatic feed(input int n, input logic [7:0] base, input bit gaps);
    int k = 0;
    int budget = 0;
    while (k < n) begin
      in_if.val = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_if.dat = {48'h0, base, 8'(k)};
      in_if.err = (k == 1);
      @(negedge clk);
      if (in_if.val && in_if.rdy) begin
        hs_cyc.push_back(cyc + 1);
        k++;
      end
      @(posedge clk); #1;
      budget++;
      if (budget > 500) begin
        bound_fail("feed_words");
        break;
      end
    end
    in_if.val = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 500 && q_out.size() < n; t++) @(posedge clk);
    #1;
    if (q_out.size() < n) bound_fail("wait_output");
  endtask

  task automatic check_pkt(input string nm, input int n, input logic [2:0] lmod,
                           input logic [7:0] c, input logic [7:0] base,
                           input int first, input bit has_eop);
    wait_out(n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      logic  e_eop;
      if (q_out.size() == 0) break;
      b = q_out.pop_front();
      e_eop = has_eop && (k == n - 1);
      chk($sformatf("%s_w%0d", nm, k),
          {b.dat, b.sop, b.eop, b.err, b.mod, b.ctl},
          {{48'h0, base, 8'(k + first)}, (k == 0), e_eop, (k + first == 1),
           (e_eop ? lmod : 3'd0), c});
    end
  endtask

  task automatic check_quiet(input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk(nm, q_out.size(), 0);
    q_out.delete();
  endtask

  initial begin
    vec_t vecs[5];
    int   acc, acc_a, acc_b;

    vecs[0] = '{16'd20, 8'hA5, 3, 3'd4, 1'b0, 1'b0};
    vecs[1] = '{16'd16, 8'h3C, 2, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{16'd1,  8'h01, 1, 3'd1, 1'b0, 1'b0};
    vecs[3] = '{16'd13, 8'h7E, 2, 3'd5, 1'b0, 1'b0};
    vecs[4] = '{16'd64, 8'hC3, 8, 3'd0, 1'b1, 1'b1};

    in_if.val = 1'b0; in_if.dat = '0; in_if.err = 1'b0;
    in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.mod = '0; in_if.ctl = '0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ctrl", {len_rdy, out_if.val, zero_len, in_if.rdy}, 4'b0000);
    chk("reset_fields", {out_if.sop, out_if.eop, out_if.err, out_if.mod, out_if.ctl, out_if.dat}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("len_rdy_after_reset", len_rdy, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      bp_rand = vecs[i].bp;
      hs_cyc.delete();
      fork
        desc(vecs[i].len, vecs[i].ctl, acc);
        feed(vecs[i].nw, 8'(i + 1), vecs[i].gaps);
      join
      wait_out(vecs[i].nw);
      if (i == 0) begin
        for (int k = 0; k < 3; k++)
          if (k < q_out.size() && k < hs_cyc.size())
            chk($sformatf("latency_w%0d", k), q_out[k].cyc, hs_cyc[k]);
      end
      check_pkt($sformatf("vec%0d", i), vecs[i].nw, vecs[i].lmod, vecs[i].ctl,
                8'(i + 1), 0, 1'b1);
      bp_rand = 1'b0;
      check_quiet($sformatf("vec%0d_extra", i));
    end

    // Zero-length descriptor is swallowed with a single pulse.
    desc(16'd0, 8'h55, acc);
    @(negedge clk);
    chk("zero_len_pulse", {zero_len, out_if.val, len_rdy}, 3'b101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_len_clear", {zero_len, out_if.val}, 2'b00);
    @(posedge clk); #1;
    fork
      desc(16'd8, 8'h99, acc);
      feed(1, 8'h08, 1'b0);
    join
    check_pkt("len8", 1, 3'd0, 8'h99, 8'h08, 0, 1'b1);
    check_quiet("len8_extra");

    // Back-to-back descriptors over one continuous word stream.
    hs_cyc.delete();
    fork
      begin
        desc(16'd9, 8'h11, acc_a);
        desc(16'd24, 8'h22, acc_b);
      end
      feed(5, 8'h90, 1'b0);
    join
    check_pkt("b2b_a", 2, 3'd1, 8'h11, 8'h90, 0, 1'b1);
    check_pkt("b2b_b", 3, 3'd0, 8'h22, 8'h90, 2, 1'b1);
    if (hs_cyc.size() > 2) chk("b2b_word2_after_desc", hs_cyc[2] > acc_b, 1'b1);
    else bound_fail("b2b_word2_missing");
    check_quiet("b2b_extra");

    // Reset after two words of a four-word packet.
    hs_cyc.delete();
    fork
      desc(16'd32, 8'h44, acc);
      feed(2, 8'hA0, 1'b0);
    join
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_out", {out_if.val, out_if.eop, len_rdy}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_len_rdy", len_rdy, 1'b1);
    @(posedge clk); #1;
    check_pkt("rst_partial", 2, 3'd0, 8'h44, 8'hA0, 0, 1'b0);
    check_quiet("rst_partial_extra");
    fork
      desc(16'd8, 8'h66, acc);
      feed(1, 8'hB0, 1'b0);
    join
    check_pkt("post_rst", 1, 3'd0, 8'h66, 8'hB0, 0, 1'b1);
    check_quiet("post_rst_extra");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
